// File: rtl/memory_lsu_pkg.sv
// Shared encodings for memory_lsu: op one-hot layouts, FSM states and access sizes.
// Imported by memory_lsu and memory_lsu_lane_align.
package memory_lsu_pkg;

    localparam int LOAD_WIDTH  = 7;
    localparam int STORE_WIDTH = 4;
    localparam int LSU_STATE_W = 2;

    // Bit positions inside the one-hot op vectors
    localparam int LD_LB  = 0;
    localparam int LD_LH  = 1;
    localparam int LD_LW  = 2;
    localparam int LD_LD  = 3;
    localparam int LD_LBU = 4;
    localparam int LD_LHU = 5;
    localparam int LD_LWU = 6;

    localparam int SO_SB = 0;
    localparam int SO_SH = 1;
    localparam int SO_SW = 2;
    localparam int SO_SD = 3;

    typedef enum logic [LSU_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    function automatic int lane_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/memory_lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/data, load extraction with
// sign/zero extension, and the natural-alignment check.
module memory_lsu_lane_align
    import memory_lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int LANE_W = 3
) (
    input  lsu_size_e          i_size,
    input  logic               i_signed,
    input  logic [LANE_W-1:0]  i_lane,
    input  logic [XLEN-1:0]    i_wdata,
    input  logic [XLEN-1:0]    i_rdata,
    output logic [XLEN/8-1:0]  o_wstrb,
    output logic [XLEN-1:0]    o_wdata,
    output logic [XLEN-1:0]    o_rdata,
    output logic               o_misaligned
);

    localparam int STRB_W = XLEN / 8;

    logic [2:0]        w_bytes_m1;
    logic [7:0]        w_strb_base;
    logic [LANE_W+2:0] w_bit_off;
    logic [6:0]        w_fill;
    logic [XLEN-1:0]   w_rshift;
    logic [XLEN-1:0]   w_rleft;

    // Access size to byte count and base strobe
    always_comb begin
        w_bytes_m1  = 3'd0;
        w_strb_base = 8'h01;
        case (i_size)
            SZ_B:    begin w_bytes_m1 = 3'd0; w_strb_base = 8'h01; end
            SZ_H:    begin w_bytes_m1 = 3'd1; w_strb_base = 8'h03; end
            SZ_W:    begin w_bytes_m1 = 3'd3; w_strb_base = 8'h0F; end
            SZ_D:    begin w_bytes_m1 = 3'd7; w_strb_base = 8'hFF; end
            default: begin w_bytes_m1 = 3'd0; w_strb_base = 8'h01; end
        endcase
    end

    assign w_bit_off    = {i_lane, 3'b000};
    assign o_misaligned = |(i_lane & w_bytes_m1[LANE_W-1:0]);
    assign o_wstrb      = STRB_W'(w_strb_base) << i_lane;
    assign o_wdata      = i_wdata << w_bit_off;

    // Push the wanted field to the top, then shift back to extend it
    assign w_rshift = i_rdata >> w_bit_off;
    assign w_fill   = 7'(XLEN) - {1'b0, w_bytes_m1, 3'b111} - 7'd1;
    assign w_rleft  = w_rshift << w_fill;

    // Sign or zero extension of the extracted field
    always_comb begin
        o_rdata = '0;
        if (i_signed) begin
            o_rdata = $signed(w_rleft) >>> w_fill;
        end else begin
            o_rdata = w_rleft >> w_fill;
        end
    end

endmodule

// File: rtl/memory_lsu.sv
// Multi-cycle load/store unit on a req/gnt/rvalid bus; stalls execute until done.
// Optional build macro LSU_TIMEOUT_EN adds a TIMEOUT_CYCLES wait limit.
module memory_lsu
    import memory_lsu_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
    input  logic [STORE_WIDTH-1:0] ED_store_op_i,
    input  logic [XLEN-1:0]        ED_valE_i,
    input  logic [XLEN-1:0]        ED_rs2_data_i,
    input  logic                   execute_vaild_i,
    output logic [XLEN-1:0]        M_valM_o,
    output logic                   M_valid_o,
    output logic                   M_stall_o,
    output logic                   M_misalign_o,
    output logic                   M_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [XLEN-1:0]        mem_wdata_o,
    output logic [XLEN/8-1:0]      mem_wstrb_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [XLEN-1:0]        mem_rdata_i,
    input  logic                   mem_err_i
);

    localparam int LANE_W = lane_w(XLEN);
    localparam int STRB_W = XLEN / 8;

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_load;
    lsu_size_e         r_size;
    logic              r_signed;
    logic [LANE_W-1:0] r_lane;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_valid;
    logic              r_err;
    logic              r_misalign;
    logic [XLEN-1:0]   r_valm;

    lsu_size_e         w_in_size;
    logic              w_in_load;
    logic              w_in_signed;
    logic              w_illegal;
    logic              w_accept;
    logic [LANE_W-1:0] w_in_lane;

    lsu_size_e         w_al_size;
    logic              w_al_signed;
    logic [LANE_W-1:0] w_al_lane;
    logic [STRB_W-1:0] w_al_wstrb;
    logic [XLEN-1:0]   w_al_wdata;
    logic [XLEN-1:0]   w_al_rdata;
    logic              w_misaligned;

    logic              w_timeout;
    logic              w_done_err;
    logic              w_done_mis;
    logic [XLEN-1:0]   w_done_valm;
    logic              w_unused_vale;

    // Size decode of the incoming one-hot op
    always_comb begin
        w_in_size = SZ_D;
        if (ED_load_op_i[LD_LB] || ED_load_op_i[LD_LBU] || ED_store_op_i[SO_SB]) begin
            w_in_size = SZ_B;
        end else if (ED_load_op_i[LD_LH] || ED_load_op_i[LD_LHU] || ED_store_op_i[SO_SH]) begin
            w_in_size = SZ_H;
        end else if (ED_load_op_i[LD_LW] || ED_load_op_i[LD_LWU] || ED_store_op_i[SO_SW]) begin
            w_in_size = SZ_W;
        end else begin
            w_in_size = SZ_D;
        end
    end

    assign w_in_load   = |ED_load_op_i;
    assign w_in_signed = ED_load_op_i[LD_LB] | ED_load_op_i[LD_LH] | ED_load_op_i[LD_LW];
    assign w_illegal   = (XLEN == 32) &&
                         (ED_load_op_i[LD_LD] || ED_load_op_i[LD_LWU] || ED_store_op_i[SO_SD]);
    assign w_accept    = (r_state == ST_IDLE) && execute_vaild_i &&
                         ((|ED_load_op_i) || (|ED_store_op_i));
    assign w_in_lane   = ED_valE_i[LANE_W-1:0];
    assign w_unused_vale = ^ED_valE_i;

    // Idle steers the incoming op through the aligner; afterwards the latched one
    assign w_al_size   = (r_state == ST_IDLE) ? w_in_size   : r_size;
    assign w_al_signed = (r_state == ST_IDLE) ? w_in_signed : r_signed;
    assign w_al_lane   = (r_state == ST_IDLE) ? w_in_lane   : r_lane;

    memory_lsu_lane_align #(
        .XLEN   (XLEN),
        .LANE_W (LANE_W)
    ) u_align (
        .i_size       (w_al_size),
        .i_signed     (w_al_signed),
        .i_lane       (w_al_lane),
        .i_wdata      (ED_rs2_data_i),
        .i_rdata      (mem_rdata_i),
        .o_wstrb      (w_al_wstrb),
        .o_wdata      (w_al_wdata),
        .o_rdata      (w_al_rdata),
        .o_misaligned (w_misaligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_tcnt;

    // Wait-limit counter, restarted on every entry to REQ
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tcnt <= '0;
        end else if ((w_next == ST_REQ) && (r_state != ST_REQ)) begin
            r_tcnt <= '0;
        end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
            r_tcnt <= r_tcnt + TO_W'(1);
        end
    end

    assign w_timeout = ((r_state == ST_REQ) || (r_state == ST_WAIT)) &&
                       (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
`endif

    // Next-state and completion status
    always_comb begin
        w_next      = r_state;
        w_done_err  = 1'b0;
        w_done_mis  = 1'b0;
        w_done_valm = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_illegal) begin
                    w_next     = ST_DONE;
                    w_done_err = 1'b1;
                end else if (w_accept && w_misaligned) begin
                    w_next     = ST_DONE;
                    w_done_err = 1'b1;
                    w_done_mis = 1'b1;
                end else if (w_accept) begin
                    w_next = ST_REQ;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_timeout) begin
                    w_next     = ST_DONE;
                    w_done_err = 1'b1;
                end else if (mem_gnt_i) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (w_timeout) begin
                    w_next     = ST_DONE;
                    w_done_err = 1'b1;
                end else if (mem_rvalid_i) begin
                    w_next     = ST_DONE;
                    w_done_err = mem_err_i;
                    if (r_load && !mem_err_i) begin
                        w_done_valm = w_al_rdata;
                    end else begin
                        w_done_valm = '0;
                    end
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, bus request and completion registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
            r_valm     <= '0;
        end else begin
            r_state    <= w_next;
            r_req      <= (w_next == ST_REQ);
            r_valid    <= (w_next == ST_DONE);
            r_err      <= w_done_err;
            r_misalign <= w_done_mis;
            r_valm     <= w_done_valm;
        end
    end

    // Access fields captured on accept and held stable through REQ/WAIT
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_load   <= 1'b0;
            r_size   <= SZ_B;
            r_signed <= 1'b0;
            r_lane   <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_accept) begin
            r_load   <= w_in_load;
            r_size   <= w_in_size;
            r_signed <= w_in_signed;
            r_lane   <= w_in_lane;
            r_we     <= ~w_in_load;
            r_addr   <= {ED_valE_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            r_wdata  <= w_al_wdata;
            r_wstrb  <= w_in_load ? '0 : w_al_wstrb;
        end
    end

    assign M_valM_o     = r_valm;
    assign M_valid_o    = r_valid;
    assign M_misalign_o = r_misalign;
    assign M_err_o      = r_err;
    assign M_stall_o    = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign mem_req_o    = r_req;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_wstrb_o  = r_wstrb;

endmodule

// File: tb/tb_memory_lsu.sv
// Randomized self-checking bench for memory_lsu at XLEN=64 against a byte-level
// reference model; the timeout scenario runs only when LSU_TIMEOUT_EN is defined.
module tb_memory_lsu;

    localparam int TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  ld_op;
    logic [3:0]  st_op;
    logic [63:0] vale;
    logic [63:0] rs2;
    logic        ex_valid;
    logic [63:0] valm;
    logic        m_valid, m_stall, m_mis, m_err;
    logic        req, we;
    logic [31:0] addr_o;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        gnt, rvalid, merr;
    logic [63:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Access sizes and signedness straight from the op mnemonics
    int ld_nb[7] = '{1, 2, 4, 8, 1, 2, 4};
    bit ld_sg[7] = '{1, 1, 1, 0, 0, 0, 0};
    int st_nb[4] = '{1, 2, 4, 8};

    always #5 clk = ~clk;

    memory_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i(clk), .rst_i(rst),
        .ED_load_op_i(ld_op), .ED_store_op_i(st_op),
        .ED_valE_i(vale), .ED_rs2_data_i(rs2), .execute_vaild_i(ex_valid),
        .M_valM_o(valm), .M_valid_o(m_valid), .M_stall_o(m_stall),
        .M_misalign_o(m_mis), .M_err_o(m_err),
        .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr_o),
        .mem_wdata_o(wdata), .mem_wstrb_o(wstrb),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .mem_err_i(merr)
    );

    always @(negedge clk) begin
        if (ex_valid) begin
            assert ($onehot({ld_op, st_op})) else $error("illegal op encoding presented");
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] low_bytes(input int nb);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < nb; i++) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [63:0] load_ref(input logic [63:0] rd, input int lane,
                                             input int nb, input bit sg);
        logic [63:0] v;
        v = (rd >> (8 * lane)) & low_bytes(nb);
        if (sg && (nb < 8) && v[8*nb-1]) v = v | ~low_bytes(nb);
        return v;
    endfunction

    task automatic drop_inputs();
        ex_valid = 1'b0;
        ld_op    = '0;
        st_op    = '0;
    endtask

    task automatic access(input bit is_ld, input int op, input logic [63:0] a,
                          input logic [63:0] d, input int gdly, input int rdly,
                          input logic [63:0] rd, input bit e, input string tag);
        int nb, lane, lat;
        bit sg, mis;
        logic [63:0] ebm, ewd, evalm;
        logic [7:0]  es;
        nb   = is_ld ? ld_nb[op] : st_nb[op];
        sg   = is_ld ? ld_sg[op] : 1'b0;
        lane = int'(a[2:0]);
        mis  = (lane % nb) != 0;
        es = '0; ebm = '0; ewd = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= lane && i < lane + nb) begin
                es[i]          = 1'b1;
                ebm[i*8 +: 8]  = 8'hFF;
                ewd[i*8 +: 8]  = d[(i-lane)*8 +: 8];
            end
        end
        evalm = (e || !is_ld) ? 64'd0 : load_ref(rd, lane, nb, sg);
        lat = 0;
        @(posedge clk); #1;
        ld_op = is_ld ? 7'(1 << op) : 7'd0;
        st_op = is_ld ? 4'd0 : 4'(1 << op);
        vale = a; rs2 = d; ex_valid = 1'b1;
        @(negedge clk);
        check({tag, ".stall_accept"}, 64'(m_stall), 64'd1);
        check({tag, ".noreq_accept"}, 64'(req), 64'd0);
        if (mis) begin
            @(posedge clk); #1; lat++;
            drop_inputs();
            @(negedge clk);
            check({tag, ".req_mis"}, 64'(req), 64'd0);
        end else begin
            for (int c = 0; c <= gdly; c++) begin
                @(posedge clk); #1; lat++;
                gnt = (c == gdly);
                @(negedge clk);
                check({tag, ".req"},   64'(req), 64'd1);
                check({tag, ".addr"},  {32'd0, addr_o}, {32'd0, a[31:3], 3'b000});
                check({tag, ".we"},    64'(we), 64'(!is_ld));
                check({tag, ".stall"}, 64'(m_stall), 64'd1);
                if (!is_ld) begin
                    check({tag, ".wstrb"}, 64'(wstrb), 64'(es));
                    check({tag, ".wdata"}, wdata & ebm, ewd);
                end
            end
            @(posedge clk); #1; lat++;
            gnt = 1'b0;
            for (int c = 0; c <= rdly; c++) begin
                if (c > 0) begin @(posedge clk); #1; lat++; end
                rvalid = (c == rdly); rdata = rd; merr = e;
                @(negedge clk);
                check({tag, ".req_wait"},   64'(req), 64'd0);
                check({tag, ".stall_wait"}, 64'(m_stall), 64'd1);
                check({tag, ".valid_wait"}, 64'(m_valid), 64'd0);
            end
            @(posedge clk); #1; lat++;
            rvalid = 1'b0; merr = 1'b0;
            drop_inputs();
            @(negedge clk);
        end
        check({tag, ".valid"},    64'(m_valid), 64'd1);
        check({tag, ".latency"},  64'(lat), mis ? 64'd1 : 64'(3 + gdly + rdly));
        check({tag, ".misalign"}, 64'(m_mis), 64'(mis));
        check({tag, ".err"},      64'(m_err), 64'(mis || e));
        check({tag, ".valm"},     valm, mis ? 64'd0 : evalm);
        check({tag, ".stall_done"}, 64'(m_stall), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, ".pulse"}, 64'(m_valid), 64'd0);
    endtask

    initial begin
        bit          is_ld;
        int          op, nb, lane, gd, rdl;
        logic [63:0] a, d, rd;
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; rdata = '0;
        vale = '0; rs2 = '0;
        drop_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.outs", {valm | wdata | 64'(addr_o) | 64'(wstrb)}, 64'd0);
        check("rst.ctrl", 64'({m_valid, m_stall, m_mis, m_err, req, we}), 64'd0);
        rst = 1'b0;

        access(1'b0, 2, 64'h1004, 64'h11223344, 0, 0, '0, 1'b0, "sw");
        access(1'b1, 0, 64'h1003, '0, 1, 0, 64'h0000_0000_8000_0000, 1'b0, "lb");
        access(1'b1, 4, 64'h1003, '0, 0, 1, 64'h0000_0000_8000_0000, 1'b0, "lbu");
        access(1'b1, 2, 64'h1002, '0, 0, 0, '0, 1'b0, "lw_mis");
        access(1'b1, 3, 64'h2000, '0, 3, 0, 64'hDEAD_BEEF_0123_4567, 1'b1, "ld_err");

        for (int t = 0; t < 60; t++) begin
            is_ld = 1'($urandom_range(0, 1));
            op    = is_ld ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 3));
            nb    = is_ld ? ld_nb[op] : st_nb[op];
            lane  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 8 / nb - 1)) * nb
                                                : int'($urandom_range(0, 7));
            a     = {$urandom, $urandom};
            a[2:0] = 3'(lane);
            d     = {$urandom, $urandom};
            rd    = {$urandom, $urandom};
            gd    = int'($urandom_range(0, 3));
            rdl   = int'($urandom_range(0, 2));
            access(is_ld, op, a, d, gd, rdl, rd, ($urandom_range(0, 7) == 0), "rand");
        end

        // Reset while requesting: request must drop without waiting for a clock edge
        @(posedge clk); #1;
        ld_op = 7'b000_1000; vale = 64'h3000; ex_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstreq.req_before", 64'(req), 64'd1);
        drop_inputs();
        #1 rst = 1'b1;
        #1 check("rstreq.req_async", 64'(req), 64'd0);
        check("rstreq.stall", 64'(m_stall), 64'd0);
        #1 rst = 1'b0;

        // Reset in WAIT, then a stray response must not complete anything
        @(posedge clk); #1;
        ld_op = 7'b000_1000; vale = 64'h2000; ex_valid = 1'b1;
        @(posedge clk); #1; gnt = 1'b1;
        @(posedge clk); #1; gnt = 1'b0;
        @(negedge clk);
        check("rstwait.stall_before", 64'(m_stall), 64'd1);
        drop_inputs();
        #1 rst = 1'b1;
        #1 check("rstwait.req", 64'(req), 64'd0);
        check("rstwait.stall", 64'(m_stall), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1; rvalid = 1'b1; rdata = 64'h55;
        @(negedge clk);
        check("stray.valid0", 64'(m_valid), 64'd0);
        @(posedge clk); #1; rvalid = 1'b0;
        @(negedge clk);
        check("stray.valid1", 64'({m_valid, m_err, m_stall}), 64'd0);

`ifdef LSU_TIMEOUT_EN
        begin
            int cyc, seen;
            seen = 0;
            @(posedge clk); #1;
            ld_op = 7'b000_1000; vale = 64'h4000; ex_valid = 1'b1;
            for (cyc = 1; cyc <= 40 && seen == 0; cyc++) begin
                @(posedge clk); #1;
                drop_inputs();
                @(negedge clk);
                if (m_valid) begin
                    seen = cyc;
                    check("timeout.err", 64'(m_err), 64'd1);
                    check("timeout.req", 64'(req), 64'd0);
                end
            end
            check("timeout.seen", 64'(seen != 0), 64'd1);
            check("timeout.after_limit", 64'(seen > TO_CYC), 64'd1);
            @(posedge clk); #1; rvalid = 1'b1;
            @(posedge clk); #1; rvalid = 1'b0;
            @(negedge clk);
            check("timeout.late_rvalid", 64'(m_valid), 64'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_lsu.md
Name: memory_lsu

Overview:
- Parametrised successor to the combinational DPI memory stage: a multi-cycle load/store unit between execute and writeback.
- Drives a request/grant/response memory bus instead of DPI calls.
- Supports XLEN 32 or 64, byte-lane strobes, lb/lh/lw/ld/lbu/lhu/lwu and sb/sh/sw/sd, plus misalignment and bus-error reporting.
- Stalls the pipeline until each access completes.

Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64.
- ADDR_W, 32, bus address width.
- TIMEOUT_CYCLES, 256, wait limit. Used only with LSU_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- ED_load_op_i  in  `LOAD_WIDTH  one-hot load op.
- ED_store_op_i  in  `STORE_WIDTH  one-hot store op.
- ED_valE_i  in  XLEN  effective address; low ADDR_W bits used.
- ED_rs2_data_i  in  XLEN  store data.
- execute_vaild_i  in  1  execute stage holds a valid instruction.
- M_valM_o  out  XLEN  extended load result.
- M_valid_o  out  1  one-cycle completion pulse.
- M_stall_o  out  1  pipeline must hold its ED_* inputs.
- M_misalign_o  out  1  completion was a misaligned access.
- M_err_o  out  1  completion was a bus error, timeout or illegal width.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  address aligned down to XLEN/8.
- mem_wdata_o  out  XLEN  store data shifted into its byte lanes.
- mem_wstrb_o  out  XLEN/8  byte strobes.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response valid; acknowledges both loads and stores.
- mem_rdata_i  in  XLEN  read data.
- mem_err_i  in  1  error flag, qualified by mem_rvalid_i.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset asserted mid-access drops mem_req_o immediately, and any later rvalid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE. Encodings are defined in define.v.
- IDLE:
  - If execute_vaild_i and any op bit is set, latch the op, lane offset, byte strobes and shifted wdata.
  - Alignment check: lh/lhu/sh need addr[0]=0; lw/lwu/sw need addr[1:0]=0; ld/sd need addr[2:0]=0.
  - Aligned access goes to REQ. Misaligned access goes to DONE with misalign=1, err=1 and no bus activity.
  - ld/lwu/sd with XLEN=32 go to DONE with err=1.
- REQ:
  - mem_req_o=1; mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o stay stable until mem_gnt_i.
  - Leave for WAIT on mem_gnt_i.
- WAIT:
  - On mem_rvalid_i, capture mem_rdata_i and mem_err_i, then go to DONE.
  - rvalid in the same cycle as gnt is not legal; the slave responds no earlier than the cycle after gnt.
- DONE:
  - M_valid_o=1 for exactly one cycle, then IDLE.
  - M_misalign_o and M_err_o are valid only in this cycle.
- Stall: M_stall_o = (IDLE & new op accepted) | REQ | WAIT. It is 0 in DONE, so the pipeline advances.
- Minimum latency: accept in cycle 0, request in cycle 1, response in cycle 2, M_valid_o in cycle 3.
- Load extraction: shift mem_rdata_i right by lane*8 bits, then sign-extend (lb/lh/lw) or zero-extend (lbu/lhu/lwu) to XLEN. ld passes through unchanged.
- Store data: replicate rs2 low bytes, shifted to the lane. Strobe is 1/3/0xF/0xFF for byte/half/word/dword, shifted left by lane.
- On error, M_valM_o=0.
- Inputs must be one-hot. Simultaneous load and store, or multiple op bits set, is illegal; the bench asserts this.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter runs in REQ and WAIT and clears on entry to REQ. At TIMEOUT_CYCLES it forces DONE with M_err_o=1 and drops mem_req_o; a late rvalid is ignored in IDLE.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Add to define.v:
  - LSU state encodings.
  - LSU_STATE_W.
  - Byte-lane width macro LANE_W = log2(XLEN/8).
  - Access-size codes (B/H/W/D).
- One combinational sub-module, lsu_lane_align: size and lane in, giving wstrb, shifted wdata, extracted/extended rdata and the misaligned flag.

Test Plan (XLEN=64):
- sw: addr 0x1004, rs2 0x11223344, gnt after 0 cycles → mem_addr_o 0x1000, mem_wstrb_o 0xF0, mem_wdata_o[63:32]=0x11223344; M_valid_o 3 cycles after accept.
- lb: addr 0x1003, rdata 0x0000000080000000 → M_valM_o 0xFFFFFFFFFFFFFF80. lbu at the same address → 0x80.
- lw at 0x1002 → no mem_req_o; M_valid_o, M_misalign_o and M_err_o high in cycle 1; stall high only in cycle 0.
- ld at 0x2000 with gnt delayed 3 cycles → mem_req_o and mem_addr_o held stable for 4 cycles, M_stall_o high throughout. rvalid with mem_err_i=1 → M_err_o=1, M_valM_o=0.
- rst_i pulsed in WAIT → mem_req_o=0 asynchronously, FSM in IDLE. A subsequent stray rvalid produces no M_valid_o.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and gnt never asserted → M_err_o with M_valid_o after the timeout expires.
